// File: rtl/tradeoff_52bits_pkg.sv
// Shared constants and state encoding for the 52-bit saturating /65537 divider.
package tradeoff_52bits_pkg;

    localparam int TB_W_BITS = 69;
    localparam int TB_N_BITS = 53;

    localparam logic [16:0] DIVISOR = 17'd65537;
    localparam logic [52:0] N_MAX   = 53'd4503599627370495;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tradeoff_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module tradeoff_div_step
    import tradeoff_52bits_pkg::*;
(
    input  logic [16:0] rem,
    input  logic        din,
    output logic [16:0] rem_nxt,
    output logic        qbit
);

    logic [17:0] trial;

    // The remainder is always below DIVISOR, so trial < 2*DIVISOR and the
    // difference fits in 17 bits; modulo-2^17 subtraction is therefore exact.
    always_comb begin
        trial   = {rem, din};
        qbit    = (trial >= {1'b0, DIVISOR});
        rem_nxt = qbit ? (trial[16:0] - DIVISOR) : trial[16:0];
    end

endmodule

// File: rtl/tradeoff_52bits.sv
// Iterative saturating divider: N = min(floor(W / 65537), 2^52-1), one quotient bit per clock.
module tradeoff_52bits
    import tradeoff_52bits_pkg::*;
#(
    parameter int W_BITS = TB_W_BITS,
    parameter int N_BITS = TB_N_BITS
) (
    input  logic              clk,
    input  logic              rst_n,   // active-high despite the name
    input  logic [W_BITS-1:0] W,
    output logic              found,
    output logic [N_BITS-1:0] N
);

    localparam int CNT_W = $clog2(W_BITS);

    state_t            state, state_nxt;
    logic [W_BITS-1:0] w_q;
    logic [16:0]       rem, rem_nxt;
    logic [W_BITS-1:0] quo, quo_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              restart_pending;
    logic              qbit;
    logic              capture;
    logic              last_iter;
    logic [N_BITS-1:0] n_sat;

    tradeoff_div_step u_step (
        .rem     (rem),
        .din     (w_q[cnt]),
        .rem_nxt (rem_nxt),
        .qbit    (qbit)
    );

    // Any change of W against the latched operand abandons current work.
    assign capture   = restart_pending || ((state != IDLE) && (W != w_q));
    assign last_iter = (state == RUN) && (cnt == '0);
    assign quo_nxt   = (quo << 1) | {{(W_BITS-1){1'b0}}, qbit};
    assign n_sat     = (quo_nxt > {{(W_BITS-N_BITS){1'b0}}, N_MAX}) ? N_MAX : quo_nxt[N_BITS-1:0];

    // State register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; a restart takes priority over finishing.
    always_comb begin
        state_nxt = state;
        if (capture)        state_nxt = RUN;
        else if (last_iter) state_nxt = DONE;
    end

    // Output logic: valid only while the latched operand still matches live W.
    always_comb begin
        found = (state == DONE) && (W == w_q);
    end

    // Datapath: operand capture, shift-subtract iteration, result landing.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            w_q             <= '0;
            rem             <= '0;
            quo             <= '0;
            cnt             <= '0;
            restart_pending <= 1'b1;
            N               <= '0;
        end else if (capture) begin
            w_q             <= W;
            rem             <= '0;
            quo             <= '0;
            cnt             <= CNT_W'(W_BITS-1);
            restart_pending <= 1'b0;
        end else if (state == RUN) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt - 1'b1;
            if (last_iter) N <= n_sat;
        end
    end

endmodule

// File: tb/tb_tradeoff_52bits.sv
// Directed-vector bench for tradeoff_52bits.
module tb_tradeoff_52bits;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [68:0] W = '0;
    logic        found;
    logic [52:0] N;

    int nvec = 0;
    int nerr = 0;

    localparam logic [52:0] NMAX = 53'd4503599627370495;

    tradeoff_52bits dut (
        .clk   (clk),
        .rst_n (rst_n),
        .W     (W),
        .found (found),
        .N     (N)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts rising edges until found is seen high (sampled at negedge), bounded.
    // Also checks that N stays at old_n while found is low.
    task automatic wait_found(input string tag, input logic [52:0] old_n, output int n);
        int bad_found = 0;
        int bad_hold  = 0;
        n = 0;
        while (!found && n < 200) begin
            @(negedge clk);
            n++;
            if (n < 70 && found)  bad_found++;
            if (n < 70 && N !== old_n) bad_hold++;
        end
        chk({tag, "_early_found"}, 69'(bad_found), 69'd0);
        chk({tag, "_n_hold"}, 69'(bad_hold), 69'd0);
        chk({tag, "_latency"}, 69'(n), 69'd70);
    endtask

    task automatic run_vec(input string tag, input logic [68:0] w, input logic [52:0] exp_n);
        int n;
        logic [52:0] old_n;
        @(negedge clk);
        old_n = N;
        W = w;
        #1;
        chk({tag, "_found_drop"}, 69'(found), 69'd0);
        wait_found(tag, old_n, n);
        chk({tag, "_N"}, 69'(N), 69'(exp_n));
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_found", 69'(found), 69'd0);
        chk("rst_N", 69'(N), 69'd0);

        // First vector captured on release: 65537 * N_MAX
        W = 69'd295152408778980130815;
        rst_n = 1'b0;
        wait_found("first", 53'd0, n);
        chk("first_N", 69'(N), 69'(NMAX));
        repeat (5) @(negedge clk);
        chk("first_hold", 69'(found), 69'd1);
        chk("first_hold_N", 69'(N), 69'(NMAX));

        run_vec("nmax_m1", 69'd295152408778980130814, 53'd4503599627370494);
        run_vec("one",     69'd65537, 53'd1);
        run_vec("below",   69'd65536, 53'd0);
        run_vec("zero",    69'd0,     53'd0);
        run_vec("all1",    69'd590295810358705651711, NMAX);
        run_vec("two",     69'd131074, 53'd2);

        // Mid-run operand change: only the latest W may produce a result
        @(negedge clk);
        W = 69'd295152408778980130815;
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (found) n++;
        end
        chk("midrun_found_low", 69'(n), 69'd0);
        run_vec("midrun", 69'd655370, 53'd10);

        // Reset asserted mid-run clears outputs without a clock edge
        @(negedge clk);
        W = 69'd65537000;
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("midrst_found", 69'(found), 69'd0);
        chk("midrst_N", 69'(N), 69'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        wait_found("postrst", 53'd0, n);
        chk("postrst_N", 69'(N), 69'd1000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
